// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // True when addr selects a real entry; only matters for non-power-of-2 depths.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, optional write-first bypass,
// registered data and one-cycle valid pulse.
// Build option: REG_FILE_BYPASS_EN selects write-first on a same-cycle collision.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          en,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem_q,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic                          addr_err
);

  logic              ok;
  logic [DATA_W-1:0] rd_next;

  assign ok       = addr_in_range(32'(addr), DEPTH);
  assign addr_err = en & ~ok;

  // Next read value: zero when out of range, else stored (or bypassed) data.
  always_comb begin
    rd_next = '0;
    if (ok) rd_next = mem_q[addr];
`ifdef REG_FILE_BYPASS_EN
    if (ok && wr_en && (wr_addr == addr)) rd_next = wr_data;
`endif
  end

`ifndef REG_FILE_BYPASS_EN
  // Write-side inputs only feed the bypass mux.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  // Data holds between reads; valid is a single-cycle pulse per read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= en;
      if (en) rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file, one write port and two registered read ports (A, B),
// with address-range error pulse and a DEPTH-cycle clear-all sequencer.
// Build option: REG_FILE_BYPASS_EN (write-first collisions; default read-first).
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdEnA,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [DATA_W-1:0] RdDataA,
  output logic              RdValidA,
  input  logic              RdEnB,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataB,
  output logic              RdValidB,
  output logic              AddrErr,
  input  logic              ClrReq,
  output logic              Busy
);

  localparam int NUM_RD = 2;

  state_t                          state;
  logic [ADDR_W-1:0]               ptr;
  logic [DEPTH-1:0][DATA_W-1:0]    mem;

  logic                            accept;
  logic                            wr_ok;
  logic                            wr_err;
  logic [NUM_RD-1:0]               rd_en;
  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]               rd_valid;
  logic [NUM_RD-1:0]               rd_err;

  // Normal traffic only in IDLE, and a clear request pre-empts it.
  assign accept  = (state == ST_IDLE) & ~ClrReq;
  assign wr_ok   = accept & WrEn &  addr_in_range(32'(WrAddr), DEPTH);
  assign wr_err  = accept & WrEn & ~addr_in_range(32'(WrAddr), DEPTH);

  assign rd_en   = {RdEnB & accept, RdEnA & accept};
  assign rd_addr = {RdAddrB, RdAddrA};

  assign RdDataA  = rd_data[0];
  assign RdValidA = rd_valid[0];
  assign RdDataB  = rd_data[1];
  assign RdValidB = rd_valid[1];
  assign Busy     = (state == ST_CLEAR);

  genvar i;
  generate
    for (i = 0; i < NUM_RD; i++) begin : g_rd
      reg_file_rd_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
      ) u_port (
        .CLK      (CLK),
        .RST      (RST),
        .en       (rd_en[i]),
        .addr     (rd_addr[i]),
        .mem_q    (mem),
        .wr_en    (wr_ok),
        .wr_addr  (WrAddr),
        .wr_data  (WrData),
        .rd_data  (rd_data[i]),
        .rd_valid (rd_valid[i]),
        .addr_err (rd_err[i])
      );
    end
  endgenerate

  // Clear sequencer: walk ptr over every entry once, then back to IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ClrReq) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Storage: clear walk has priority over host writes (which are blocked anyway).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem <= '0;
    end else if (state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[WrAddr] <= WrData;
    end
  end

  // One pulse covers any mix of offending write/read ports.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) AddrErr <= 1'b0;
    else     AddrErr <= wr_err | (|rd_err);
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: DEPTH=8 instance for the main plan,
// DEPTH=6 instance for out-of-range behaviour. Expected results come from a
// reference model and are queued per cycle, then popped after the clock edge.
module tb_reg_file_2r1w;

  localparam int DW = 16;
  localparam int AW = 3;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          we [2];
  logic          rea[2];
  logic          reb[2];
  logic          clr[2];
  logic [AW-1:0] wa [2];
  logic [AW-1:0] aa [2];
  logic [AW-1:0] ab [2];
  logic [DW-1:0] wd [2];
  logic [DW-1:0] rda[2];
  logic [DW-1:0] rdb[2];
  logic          va [2];
  logic          vb [2];
  logic          aerr[2];
  logic          busy[2];

  reg_file_2r1w #(.DATA_W(DW), .DEPTH(8)) dut8 (
    .CLK(CLK), .RST(RST),
    .WrEn(we[0]), .WrAddr(wa[0]), .WrData(wd[0]),
    .RdEnA(rea[0]), .RdAddrA(aa[0]), .RdDataA(rda[0]), .RdValidA(va[0]),
    .RdEnB(reb[0]), .RdAddrB(ab[0]), .RdDataB(rdb[0]), .RdValidB(vb[0]),
    .AddrErr(aerr[0]), .ClrReq(clr[0]), .Busy(busy[0])
  );

  reg_file_2r1w #(.DATA_W(DW), .DEPTH(6)) dut6 (
    .CLK(CLK), .RST(RST),
    .WrEn(we[1]), .WrAddr(wa[1]), .WrData(wd[1]),
    .RdEnA(rea[1]), .RdAddrA(aa[1]), .RdDataA(rda[1]), .RdValidA(va[1]),
    .RdEnB(reb[1]), .RdAddrB(ab[1]), .RdDataB(rdb[1]), .RdValidB(vb[1]),
    .AddrErr(aerr[1]), .ClrReq(clr[1]), .Busy(busy[1])
  );

  typedef struct {
    int            d;
    logic          va;
    logic [DW-1:0] da;
    logic          vb;
    logic [DW-1:0] db;
    logic          err;
    logic          busy;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] mm[2][8];
  int            depth[2] = '{8, 6};
  int            ccnt[2];
  int            cptr[2];
  logic [DW-1:0] lasta[2];
  logic [DW-1:0] lastb[2];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      we[k] = 1'b0; rea[k] = 1'b0; reb[k] = 1'b0; clr[k] = 1'b0;
      wa[k] = '0;   aa[k]  = '0;   ab[k]  = '0;   wd[k]  = '0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) mm[k][j] = '0;
      ccnt[k] = 0; cptr[k] = 0; lasta[k] = '0; lastb[k] = '0;
    end
    sbq.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s d%0d RdDataA", tag, k), 32'(rda[k]), 32'h0);
      chk($sformatf("%s d%0d RdDataB", tag, k), 32'(rdb[k]), 32'h0);
      chk($sformatf("%s d%0d RdValidA", tag, k), 32'(va[k]), 32'h0);
      chk($sformatf("%s d%0d RdValidB", tag, k), 32'(vb[k]), 32'h0);
      chk($sformatf("%s d%0d AddrErr", tag, k), 32'(aerr[k]), 32'h0);
      chk($sformatf("%s d%0d Busy", tag, k), 32'(busy[k]), 32'h0);
    end
  endtask

  // Drive one cycle on instance d, queue the model's expectation, clock, compare.
  task automatic step(input string tag, input int d, input int w, input int aw,
                      input int wdat, input int ra, input int a_a, input int rb,
                      input int a_b, input int c);
    exp_t e;
    bit   okw, oka, okb;
    idle_all();
    we[d]  = (w != 0);  wa[d] = AW'(aw);  wd[d] = DW'(wdat);
    rea[d] = (ra != 0); aa[d] = AW'(a_a);
    reb[d] = (rb != 0); ab[d] = AW'(a_b);
    clr[d] = (c != 0);

    e.d = d; e.va = 1'b0; e.vb = 1'b0; e.err = 1'b0;
    if (ccnt[d] > 0) begin
      mm[d][cptr[d]] = '0;
      cptr[d]++;
      ccnt[d]--;
    end else if (c != 0) begin
      ccnt[d] = depth[d];
      cptr[d] = 0;
    end else begin
      okw = aw  < depth[d];
      oka = a_a < depth[d];
      okb = a_b < depth[d];
      if (ra != 0) begin
        e.va = 1'b1;
        if (!oka) lasta[d] = '0;
        else if (BYP && w != 0 && okw && aw == a_a) lasta[d] = DW'(wdat);
        else lasta[d] = mm[d][a_a];
      end
      if (rb != 0) begin
        e.vb = 1'b1;
        if (!okb) lastb[d] = '0;
        else if (BYP && w != 0 && okw && aw == a_b) lastb[d] = DW'(wdat);
        else lastb[d] = mm[d][a_b];
      end
      e.err = (w != 0 && !okw) || (ra != 0 && !oka) || (rb != 0 && !okb);
      if (w != 0 && okw) mm[d][aw] = DW'(wdat);
    end
    e.da   = lasta[d];
    e.db   = lastb[d];
    e.busy = (ccnt[d] > 0);
    sbq.push_back(e);

    @(posedge CLK); #1;
    e = sbq.pop_front();
    chk($sformatf("%s d%0d RdValidA", tag, e.d), 32'(va[e.d]),   32'(e.va));
    chk($sformatf("%s d%0d RdDataA",  tag, e.d), 32'(rda[e.d]),  32'(e.da));
    chk($sformatf("%s d%0d RdValidB", tag, e.d), 32'(vb[e.d]),   32'(e.vb));
    chk($sformatf("%s d%0d RdDataB",  tag, e.d), 32'(rdb[e.d]),  32'(e.db));
    chk($sformatf("%s d%0d AddrErr",  tag, e.d), 32'(aerr[e.d]), 32'(e.err));
    chk($sformatf("%s d%0d Busy",     tag, e.d), 32'(busy[e.d]), 32'(e.busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    idle_all();
    model_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_outs("por");
    RST = 1'b0;

    // Some traffic, then reset while reads/writes are active.
    step("pre", 0, 1, 1, 'h5555, 1, 1, 0, 0, 0);
    step("pre", 0, 1, 4, 'h6666, 1, 4, 1, 1, 0);
    we[0] = 1'b1; wa[0] = 3'd1; wd[0] = 16'h7777; rea[0] = 1'b1; reb[0] = 1'b1;
    RST = 1'b1;
    #1;
    chk_reset_outs("rst_async");
    @(posedge CLK); #1;
    chk_reset_outs("rst_held");
    idle_all();
    RST = 1'b0;
    model_reset();

    // Every entry reads zero after reset.
    for (int i = 0; i < 8; i++) step("rd_after_rst", 0, 0, 0, 0, 1, i, 1, 7 - i, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Dual read of two different addresses.
    step("dual_wr", 0, 1, 3, 'hA5A5, 0, 0, 0, 0, 0);
    step("dual_wr", 0, 1, 5, 'h1234, 0, 0, 0, 0, 0);
    step("dual_rd", 0, 0, 0, 0, 1, 3, 1, 5, 0);
    step("dual_same", 0, 0, 0, 0, 1, 5, 1, 5, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle write/read collision.
    step("coll_wr", 0, 1, 2, 'h1111, 0, 0, 0, 0, 0);
    step("coll", 0, 1, 2, 'h2222, 1, 2, 0, 0, 0);
    step("coll_after", 0, 0, 0, 0, 1, 2, 1, 2, 0);

    // Clear-all: fill, request (with a competing write), traffic during Busy.
    for (int i = 0; i < 8; i++) step("fill", 0, 1, i, 'hFFFF, 0, 0, 0, 0, 0);
    step("clr_req", 0, 1, 6, 'hABCD, 1, 6, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("clr_busy", 0, 1, 0, 'h4242, 1, 0, 1, 1, (i == 2) ? 1 : 0);
    for (int i = 0; i < 8; i++) step("clr_after", 0, 0, 0, 0, 1, i, 1, 7 - i, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Out-of-range on DEPTH=6.
    for (int i = 0; i < 6; i++) step("r6_fill", 1, 1, i, 'h0100 + i, 0, 0, 0, 0, 0);
    step("r6_bad", 1, 1, 7, 'hBEEF, 0, 0, 1, 7, 0);
    step("r6_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r6_bad2", 1, 1, 6, 'hDEAD, 1, 6, 1, 2, 0);
    step("r6_badwr", 1, 1, 6, 'h5A5A, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("r6_rd", 1, 0, 0, 0, 1, i, 1, 5 - i, 0);
    step("r6_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset three cycles into a clear.
    step("mc_wr", 0, 1, 7, 'h0F0F, 0, 0, 0, 0, 0);
    step("mc_req", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("mc_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    #1;
    chk_reset_outs("mc_rst");
    @(posedge CLK); #1;
    idle_all();
    RST = 1'b0;
    model_reset();
    step("mc_wr2", 0, 1, 4, 'h3C3C, 0, 0, 0, 0, 0);
    step("mc_rd", 0, 0, 0, 0, 1, 4, 1, 7, 0);
    for (int i = 0; i < 8; i++) step("mc_quiet", 0, 1, i, 'h0A00 + i, 1, i, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("mc_rdall", 0, 0, 0, 0, 1, i, 1, 7 - i, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
